// File: rtl/fb_pkg.sv
// Shared framebuffer constants, FSM state encoding and the RGB565 pixel type.
// Imported by the fill engine, its address generator and the framebuffer.
package fb_pkg;

    localparam logic [31:0] FB_BASE         = 32'h2800_0000;
    localparam int unsigned FB_WIDTH        = 320;
    localparam int unsigned FB_HEIGHT       = 240;
    localparam int unsigned FB_STRIDE_BYTES = FB_WIDTH * 2;

    localparam int unsigned RECT_W  = 10;
    localparam int unsigned COORD_W = 11;
    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned STRB_W  = 4;
    localparam int unsigned STATE_W = 3;

    typedef logic [STATE_W-1:0] fb_state_t;

    localparam fb_state_t IDLE  = 3'd0;
    localparam fb_state_t CLIP  = 3'd1;
    localparam fb_state_t ISSUE = 3'd2;
    localparam fb_state_t GAP   = 3'd3;
    localparam fb_state_t DONE  = 3'd4;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

endpackage

// File: rtl/fb_rect_fill_if.sv
// Word-write port from the fill engine (master) to the framebuffer responder (slave).
interface fb_rect_fill_if;
    import fb_pkg::*;

    logic              mem_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_ready;

    modport master (
        output mem_valid, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready
    );

    modport slave (
        input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready
    );

endinterface

// File: rtl/fb_addr_gen.sv
// Combinational word address, byte strobes and pixel step for the pixel at (cur_x, cur_y).
module fb_addr_gen
    import fb_pkg::*;
(
    input  logic [COORD_W-1:0] cur_x_i,
    input  logic [COORD_W-1:0] cur_y_i,
    input  logic [COORD_W-1:0] x_end_i,
    output logic [ADDR_W-1:0]  addr_c_o,
    output logic [STRB_W-1:0]  wstrb_c_o,
    output logic [1:0]         step_c_o
);

    logic [29:0] pair_idx;

    // Row width is even, so the pixel-pair index is y*(W/2) + x/2.
    always_comb begin
        pair_idx = 30'(cur_y_i) * 30'(FB_WIDTH / 2) + 30'(cur_x_i[COORD_W-1:1]);
        addr_c_o = FB_BASE + {pair_idx, 2'b00};

        if (cur_x_i[0]) begin
            wstrb_c_o = 4'b1100;
            step_c_o  = 2'd1;
        end else if ((cur_x_i + COORD_W'(1)) < x_end_i) begin
            wstrb_c_o = 4'b1111;
            step_c_o  = 2'd2;
        end else begin
            wstrb_c_o = 4'b0011;
            step_c_o  = 2'd1;
        end
    end

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle-fill bus initiator for the RGB565 framebuffer: clips, then issues strobed word writes.
// Optional FB_RECT_FILL_CHECKER_EN adds color_alt and a checkerboard pattern.
module fb_rect_fill
    import fb_pkg::*;
(
    input  logic              clk_cpu,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [RECT_W-1:0] rect_x,
    input  logic [RECT_W-1:0] rect_y,
    input  logic [RECT_W-1:0] rect_w,
    input  logic [RECT_W-1:0] rect_h,
    input  logic [15:0]       color,
`ifdef FB_RECT_FILL_CHECKER_EN
    input  logic [15:0]       color_alt,
`endif
    output logic              busy,
    output logic              done,
    fb_rect_fill_if.master    mem
);

    fb_state_t         state_q, state_d;
    logic [RECT_W-1:0] rx_q, rx_d, ry_q, ry_d, rw_q, rw_d, rh_q, rh_d;
    rgb565_t           color_q, color_d;
`ifdef FB_RECT_FILL_CHECKER_EN
    rgb565_t           alt_q, alt_d;
`endif
    logic [COORD_W-1:0] x_end_q, x_end_d, y_end_q, y_end_d;
    logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic               busy_q, busy_d, done_q, done_d, valid_q, valid_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [STRB_W-1:0]  wstrb_q, wstrb_d;

    logic [COORD_W-1:0] x_sum_c, y_sum_c, x_end_c, y_end_c;
    logic [COORD_W-1:0] gen_x_c, gen_y_c, gen_xe_c, adv_x_c, adv_y_c;
    logic               empty_c;
    rgb565_t            lo_pix_c, hi_pix_c;
    logic [ADDR_W-1:0]  gen_addr_c;
    logic [STRB_W-1:0]  gen_wstrb_c;
    logic [1:0]         gen_step_c;

    // In CLIP the first write is generated straight from the latched rectangle.
    always_comb begin
        x_sum_c = COORD_W'(rx_q) + COORD_W'(rw_q);
        y_sum_c = COORD_W'(ry_q) + COORD_W'(rh_q);
        x_end_c = (x_sum_c > COORD_W'(FB_WIDTH))  ? COORD_W'(FB_WIDTH)  : x_sum_c;
        y_end_c = (y_sum_c > COORD_W'(FB_HEIGHT)) ? COORD_W'(FB_HEIGHT) : y_sum_c;
        empty_c = (rw_q == '0) || (rh_q == '0) ||
                  (COORD_W'(rx_q) >= COORD_W'(FB_WIDTH)) ||
                  (COORD_W'(ry_q) >= COORD_W'(FB_HEIGHT));

        gen_x_c  = (state_q == CLIP) ? COORD_W'(rx_q) : cur_x_q;
        gen_y_c  = (state_q == CLIP) ? COORD_W'(ry_q) : cur_y_q;
        gen_xe_c = (state_q == CLIP) ? x_end_c        : x_end_q;

`ifdef FB_RECT_FILL_CHECKER_EN
        // Even column uses color on even rows; the odd column is the opposite.
        lo_pix_c = gen_y_c[0] ? alt_q   : color_q;
        hi_pix_c = gen_y_c[0] ? color_q : alt_q;
`else
        lo_pix_c = color_q;
        hi_pix_c = color_q;
`endif

        adv_x_c = cur_x_q + COORD_W'(gen_step_c);
        adv_y_c = cur_y_q;
        if (adv_x_c >= x_end_q) begin
            adv_x_c = COORD_W'(rx_q);
            adv_y_c = cur_y_q + COORD_W'(1);
        end
    end

    fb_addr_gen u_addr_gen (
        .cur_x_i   (gen_x_c),
        .cur_y_i   (gen_y_c),
        .x_end_i   (gen_xe_c),
        .addr_c_o  (gen_addr_c),
        .wstrb_c_o (gen_wstrb_c),
        .step_c_o  (gen_step_c)
    );

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        rx_d    = rx_q;
        ry_d    = ry_q;
        rw_d    = rw_q;
        rh_d    = rh_q;
        color_d = color_q;
`ifdef FB_RECT_FILL_CHECKER_EN
        alt_d   = alt_q;
`endif
        x_end_d = x_end_q;
        y_end_d = y_end_q;
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    rx_d    = rect_x;
                    ry_d    = rect_y;
                    rw_d    = rect_w;
                    rh_d    = rect_h;
                    color_d = rgb565_t'(color);
`ifdef FB_RECT_FILL_CHECKER_EN
                    alt_d   = rgb565_t'(color_alt);
`endif
                    busy_d  = 1'b1;
                    state_d = CLIP;
                end
            end
            CLIP: begin
                x_end_d = x_end_c;
                y_end_d = y_end_c;
                if (empty_c) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    cur_x_d = COORD_W'(rx_q);
                    cur_y_d = COORD_W'(ry_q);
                    valid_d = 1'b1;
                    addr_d  = gen_addr_c;
                    wdata_d = {hi_pix_c, lo_pix_c};
                    wstrb_d = gen_wstrb_c;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (mem.mem_ready) begin
                    valid_d = 1'b0;
                    cur_x_d = adv_x_c;
                    cur_y_d = adv_y_c;
                    if ((adv_y_c >= y_end_q) || abort) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                valid_d = 1'b1;
                addr_d  = gen_addr_c;
                wdata_d = {hi_pix_c, lo_pix_c};
                wstrb_d = gen_wstrb_c;
                state_d = ISSUE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_cpu or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rx_q    <= '0;
            ry_q    <= '0;
            rw_q    <= '0;
            rh_q    <= '0;
            color_q <= '0;
`ifdef FB_RECT_FILL_CHECKER_EN
            alt_q   <= '0;
`endif
            x_end_q <= '0;
            y_end_q <= '0;
            cur_x_q <= '0;
            cur_y_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            rx_q    <= rx_d;
            ry_q    <= ry_d;
            rw_q    <= rw_d;
            rh_q    <= rh_d;
            color_q <= color_d;
`ifdef FB_RECT_FILL_CHECKER_EN
            alt_q   <= alt_d;
`endif
            x_end_q <= x_end_d;
            y_end_q <= y_end_d;
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign mem.mem_valid = valid_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Randomized bench for fb_rect_fill: a pixel-coverage model predicts every word write.
// Builds with or without FB_RECT_FILL_CHECKER_EN.
module tb_fb_rect_fill;

`ifdef FB_RECT_FILL_CHECKER_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk_cpu = 1'b0;
    logic        reset;
    logic        start, abort;
    logic [9:0]  rect_x, rect_y, rect_w, rect_h;
    logic [15:0] color, color_alt;
    logic        busy, done;

    fb_rect_fill_if mif ();

    fb_rect_fill dut (
        .clk_cpu   (clk_cpu),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .rect_x    (rect_x),
        .rect_y    (rect_y),
        .rect_w    (rect_w),
        .rect_h    (rect_h),
        .color     (color),
`ifdef FB_RECT_FILL_CHECKER_EN
        .color_alt (color_alt),
`endif
        .busy      (busy),
        .done      (done),
        .mem       (mif)
    );

    always #5 clk_cpu = ~clk_cpu;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;

    wr_t exp_q[$];
    wr_t got_q[$];
    int  total = 0;
    int  bad   = 0;
    int  resp_lat = 0;
    bit  spur = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        if (obs !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, req, $time);
        end
    endtask

    function automatic logic [15:0] pix(input int x, input int y,
                                        input logic [15:0] c, input logic [15:0] ca);
        return (CHK && (((x ^ y) & 1) != 0)) ? ca : c;
    endfunction

    // Reference: every screen word touched by the clipped rectangle, row by row, left to right.
    task automatic build_exp(input int x, input int y, input int w, input int h,
                             input logic [15:0] c, input logic [15:0] ca);
        int xe, ye;
        wr_t e;
        exp_q.delete();
        if (w == 0 || h == 0 || x >= 320 || y >= 240) return;
        xe = (x + w > 320) ? 320 : x + w;
        ye = (y + h > 240) ? 240 : y + h;
        for (int yy = y; yy < ye; yy++) begin
            for (int wd = x / 2; wd <= (xe - 1) / 2; wd++) begin
                e.addr = 32'h2800_0000 + 32'(yy * 640) + 32'(wd * 4);
                e.strb = 4'b0000;
                if (2 * wd >= x)     e.strb[1:0] = 2'b11;
                if (2 * wd + 1 < xe) e.strb[3:2] = 2'b11;
                e.data = {pix(2 * wd + 1, yy, c, ca), pix(2 * wd, yy, c, ca)};
                exp_q.push_back(e);
            end
        end
    endtask

    // Responder: ready after resp_lat extra cycles, checks hold and the mandatory gap.
    initial begin : responder
        wr_t snap;
        int  wait_cnt;
        bit  gap_chk;
        wait_cnt = 0;
        gap_chk  = 1'b0;
        snap     = '0;
        mif.mem_ready = 1'b0;
        forever begin
            @(negedge clk_cpu);
            mif.mem_ready = 1'b0;
            if (reset) begin
                wait_cnt = 0;
                gap_chk  = 1'b0;
            end else if (gap_chk) begin
                check_eq("valid_gap", 32'(mif.mem_valid), 32'd0);
                gap_chk = 1'b0;
                if (spur && $urandom_range(0, 1) == 1) mif.mem_ready = 1'b1;
            end else if (mif.mem_valid) begin
                if (wait_cnt == 0) begin
                    snap = '{mif.mem_addr, mif.mem_wdata, mif.mem_wstrb};
                end else begin
                    check_eq("hold_addr", mif.mem_addr, snap.addr);
                    check_eq("hold_data", mif.mem_wdata, snap.data);
                    check_eq("hold_strb", 32'(mif.mem_wstrb), 32'(snap.strb));
                end
                if (wait_cnt >= resp_lat) begin
                    mif.mem_ready = 1'b1;
                    got_q.push_back(snap);
                    wait_cnt = 0;
                    gap_chk  = 1'b1;
                end else begin
                    wait_cnt++;
                end
            end else if (spur && $urandom_range(0, 3) == 0) begin
                mif.mem_ready = 1'b1;
            end
        end
    end

    task automatic run_fill(input int x, input int y, input int w, input int h,
                            input logic [15:0] c, input logic [15:0] ca,
                            input int lat, input bit do_abort);
        int cyc;
        build_exp(x, y, w, h, c, ca);
        resp_lat = lat;
        got_q.delete();
        @(negedge clk_cpu);
        rect_x = 10'(x); rect_y = 10'(y); rect_w = 10'(w); rect_h = 10'(h);
        color = c; color_alt = ca; start = 1'b1;
        @(negedge clk_cpu);
        start = 1'b0;
        check_eq("busy_t1", 32'(busy), 32'd1);
        check_eq("done_t1", 32'(done), 32'd0);
        @(negedge clk_cpu);
        if (exp_q.size() == 0) begin
            check_eq("empty_done_t2", 32'(done), 32'd1);
        end else begin
            check_eq("valid_t2", 32'(mif.mem_valid), 32'd1);
            if (do_abort) abort = 1'b1;
        end
        cyc = 0;
        while (!done && cyc < 4000) begin
            @(negedge clk_cpu);
            cyc++;
        end
        check_eq("done_seen", 32'(done), 32'd1);
        check_eq("busy_at_done", 32'(busy), 32'd0);
        check_eq("valid_at_done", 32'(mif.mem_valid), 32'd0);
        abort = 1'b0;
        if (do_abort) while (exp_q.size() > 1) void'(exp_q.pop_back());
        check_eq("write_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check_eq("wr_addr", got_q[i].addr, exp_q[i].addr);
            check_eq("wr_data", got_q[i].data, exp_q[i].data);
            check_eq("wr_strb", 32'(got_q[i].strb), 32'(exp_q[i].strb));
        end
        @(negedge clk_cpu);
        check_eq("done_pulse", 32'(done), 32'd0);
        check_eq("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin : main
        int cyc;
        reset = 1'b0; start = 1'b0; abort = 1'b0;
        rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0;
        color = '0; color_alt = '0;
        #2 reset = 1'b1;
        repeat (3) @(negedge clk_cpu);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_valid", 32'(mif.mem_valid), 32'd0);
        check_eq("rst_addr", mif.mem_addr, 32'd0);
        check_eq("rst_wdata", mif.mem_wdata, 32'd0);
        check_eq("rst_wstrb", 32'(mif.mem_wstrb), 32'd0);
        reset = 1'b0;

        run_fill(0, 0, 4, 1, 16'hF800, 16'h07E0, 0, 1'b0);
        check_eq("aligned_n", 32'(got_q.size()), 32'd2);
        if (got_q.size() == 2) begin
            check_eq("aligned_a1", got_q[1].addr, 32'h2800_0004);
            check_eq("aligned_s0", 32'(got_q[0].strb), 32'hF);
        end

        run_fill(3, 2, 4, 1, 16'h001F, 16'hFFFF, 1, 1'b0);
        check_eq("odd_n", 32'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            check_eq("odd_a0", got_q[0].addr, 32'h2800_0504);
            check_eq("odd_s0", 32'(got_q[0].strb), 32'hC);
            check_eq("odd_a2", got_q[2].addr, 32'h2800_050C);
            check_eq("odd_s2", 32'(got_q[2].strb), 32'h3);
        end

        run_fill(318, 239, 10, 5, 16'h1234, 16'h4321, 0, 1'b0);
        check_eq("clip_n", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) check_eq("clip_a0", got_q[0].addr, 32'h2802_57FC);

        run_fill(10, 10, 0, 3, 16'hAAAA, 16'h5555, 0, 1'b0);
        run_fill(320, 10, 4, 3, 16'hAAAA, 16'h5555, 0, 1'b0);
        run_fill(1000, 5, 1023, 2, 16'hBEEF, 16'h0101, 0, 1'b0);
        run_fill(300, 0, 1023, 1, 16'hCAFE, 16'h0F0F, 0, 1'b0);
        run_fill(5, 7, 6, 3, 16'h7BEF, 16'h8410, 5, 1'b0);
        run_fill(0, 0, 20, 2, 16'hF00F, 16'h0FF0, 5, 1'b1);
        check_eq("abort_n", 32'(got_q.size()), 32'd1);

        // Reset while a write is outstanding.
        resp_lat = 3;
        @(negedge clk_cpu);
        rect_x = 10'd0; rect_y = 10'd0; rect_w = 10'd100; rect_h = 10'd2; start = 1'b1;
        @(negedge clk_cpu);
        start = 1'b0;
        cyc = 0;
        while (!mif.mem_valid && cyc < 20) begin
            @(negedge clk_cpu);
            cyc++;
        end
        check_eq("pre_reset_valid", 32'(mif.mem_valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        check_eq("arst_valid", 32'(mif.mem_valid), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        @(negedge clk_cpu);
        @(negedge clk_cpu);
        reset = 1'b0;
        run_fill(0, 0, 2, 1, 16'h00FF, 16'hFF00, 0, 1'b0);
        check_eq("post_rst_n", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) check_eq("post_rst_a0", got_q[0].addr, 32'h2800_0000);

        for (int i = 0; i < 40; i++) begin
            int x, y, w, h;
            x = ($urandom_range(0, 3) == 0) ? int'($urandom_range(300, 330)) : int'($urandom_range(0, 40));
            y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(230, 245)) : int'($urandom_range(0, 40));
            w = int'($urandom_range(0, 14));
            h = int'($urandom_range(0, 4));
            spur = ($urandom_range(0, 1) == 1);
            run_fill(x, y, w, h, 16'($urandom), 16'($urandom),
                     int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        end
        spur = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
